xgmii_link_sequencer: RTL and testbench
=======================================

Name: xgmii_link_sequencer

Overview:
- Per-SFP-lane controller that brings a 10GBASE-R PHY lane and its MAC out of reset in order, and decides when the link is usable.
- Instanced between the phy block (pll_locked, tx_ready, rx_ready, xgmii_rx_dc) and the SoC 156 MHz reset (reset_156_reset_n).
- Sequences PHY reset, PLL lock, TX ready, RX lock and a fault-free settle period. Holds the MAC in reset until the link is up, and retries on RX timeout or link loss.

Parameters:
- RST_PULSE, 64: cycles phy_rst is held high per reset attempt.
- RX_TIMEOUT, 156250: cycles allowed in WAIT_RX before retry (1 ms at 156.25 MHz).
- SETTLE_CYCLES, 1024: consecutive clean cycles needed before link up.
- FAULT_LIMIT, 16: consecutive fault-carrying cycles in UP that drop the link.

Ports:
- clk  in  1  xgmii clock (clk_156mhz)
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PHY PLL lock (async)
- tx_ready  in  1  PHY TX ready (async)
- rx_ready  in  1  PHY RX ready/block lock (async)
- sfp_los  in  1  SFP loss of signal (async)
- sfp_prsnt_n  in  1  SFP module present, active-low (async)
- xgmii_rx_dc  in  72  PHY RX data/control, clk domain; byte i = bits [9i+7:9i], ctrl = bit 9i+8
- phy_rst  out  1  PHY lane reset
- mac_rst  out  1  MAC reset
- sfp_txdisable  out  1  drives SFPx_TXDISABLE
- link_up  out  1  link usable
- state  out  3  current FSM state encoding
- retry_count  out  8  saturating reset-attempt counter
- local_fault  out  1  registered local-fault detect
- remote_fault  out  1  registered remote-fault detect

Behaviour:
- Reset values (rst=1 for one or more cycles): phy_rst=1, mac_rst=1, sfp_txdisable=1, link_up=0, state=RST(0), retry_count=0, local_fault=0, remote_fault=0, all counters 0, synchroniser flops 0.
- Synchronisation: all async inputs pass through 2-flop synchronisers, giving 2 cycles of latency. Below, "_s" means the synchronised value.
- Fault decode, registered (1 cycle):
  - A column is bytes 0–3 or bytes 4–7.
  - Local fault: byte0 = 0x9C with ctrl=1, bytes 1 and 2 = 0x00 with ctrl=0, byte3 = 0x01 with ctrl=0.
  - Remote fault: same pattern with byte3 = 0x02.
  - Either column matching sets the flag for that cycle. fault = local_fault | remote_fault.
- sfp_txdisable = sfp_prsnt_n_s, registered.
- FSM states:
  - RST(0): phy_rst=1, mac_rst=1, timer counts. Stay while sfp_prsnt_n_s=1. When timer = RST_PULSE-1 → WAIT_LOCK, timer cleared.
  - WAIT_LOCK(1): phy_rst=0. When pll_locked_s & tx_ready_s → WAIT_RX. No timeout.
  - WAIT_RX(2): timer counts.
    - rx_ready_s & !sfp_los_s → SETTLE, timer cleared.
    - Otherwise, timer = RX_TIMEOUT-1 → RST and retry_count++.
  - SETTLE(3): timer counts clean cycles (rx_ready_s & !sfp_los_s & !fault).
    - A fault cycle clears the timer and the state stays SETTLE.
    - !rx_ready_s or sfp_los_s → WAIT_RX, timer cleared.
    - Timer = SETTLE_CYCLES-1 on a clean cycle → UP.
  - UP(4): link_up=1, mac_rst=0.
    - sfp_los_s or !rx_ready_s → RST and retry_count++.
    - Otherwise, a consecutive-fault counter reaching FAULT_LIMIT → SETTLE (link_up=0, mac_rst=1 on the next cycle). Any non-fault cycle clears this counter.
- Global overrides, evaluated before the per-state transitions:
  - !pll_locked_s in any state except RST → RST, and retry_count++ if leaving UP.
  - sfp_prsnt_n_s=1 in any state → RST. Module removal does not increment retry_count.
- Outputs are registered and decoded from the next state, so they change in the same cycle as state.
- retry_count saturates at 255 and clears only on rst.
- Timer width = clog2(max(RST_PULSE, RX_TIMEOUT, SETTLE_CYCLES)).
- Encodings 5–7 are unused; if reached, the next state is RST.

Test Plan:
- Reset, then module present, pll_locked=1, tx_ready=1, rx_ready=1, sfp_los=0, idle data → phy_rst falls 64 cycles after rst release; link_up rises after 64 + ~2 sync + 1024 cycles; mac_rst falls with it; retry_count=0.
- rx_ready held 0 → WAIT_RX times out after exactly 156250 cycles; phy_rst reasserts for 64 cycles; retry_count = 1, 2, 3 on successive attempts.
- In SETTLE, inject a local-fault column (byte4=0x9C ctrl=1, 0x00, 0x00, 0x01) at settle cycle 500 → timer restarts; link_up only after 1024 further clean cycles. local_fault pulses 1 cycle after the injected word.
- In UP, remote fault for 15 cycles then idle → link stays up. For 16 cycles → state=SETTLE, mac_rst=1, link_up=0.
- In UP, sfp_los=1 → within 3 cycles state=RST, link_up=0, phy_rst=1, retry_count+1. Set sfp_prsnt_n=1 → sfp_txdisable=1 and FSM held in RST indefinitely, retry_count unchanged.
- Drop pll_locked in SETTLE, then assert rst mid-sequence → RST entered; after rst, all outputs at reset values and retry_count=0.

Source files
------------

// File: rtl/xgmii_link_sequencer.sv
// rtl/xgmii_link_sequencer.sv - 10GBASE-R lane bring-up sequencer: PHY/MAC reset ordering and link-up decision
module xgmii_link_sequencer #(
  parameter int RST_PULSE     = 64,
  parameter int RX_TIMEOUT    = 156250,
  parameter int SETTLE_CYCLES = 1024,
  parameter int FAULT_LIMIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        tx_ready,
  input  logic        rx_ready,
  input  logic        sfp_los,
  input  logic        sfp_prsnt_n,
  input  logic [71:0] xgmii_rx_dc,
  output logic        phy_rst,
  output logic        mac_rst,
  output logic        sfp_txdisable,
  output logic        link_up,
  output logic [2:0]  state,
  output logic [7:0]  retry_count,
  output logic        local_fault,
  output logic        remote_fault
);

  localparam int TMAX01 = (RST_PULSE > RX_TIMEOUT) ? RST_PULSE : RX_TIMEOUT;
  localparam int TMAX   = (TMAX01 > SETTLE_CYCLES) ? TMAX01 : SETTLE_CYCLES;
  localparam int TW     = $clog2(TMAX);
  localparam int FW     = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_WAIT_RX   = 3'd2,
    S_SETTLE    = 3'd3,
    S_UP        = 3'd4
  } state_t;

  state_t          st, nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [FW-1:0]   fault_cnt, fault_cnt_nxt;
  logic            retry_inc;
  logic [4:0]      sync1, sync2;
  logic            pll_s, tx_s, rx_s, los_s, prsnt_n_s, fault;

  assign {prsnt_n_s, los_s, rx_s, tx_s, pll_s} = sync2;
  assign fault = local_fault | remote_fault;
  assign state = st;

  // Sequence-ordered column: /9C/ in lane 0 as control, then 00 00 <code> as data
  function automatic logic col_match(input logic [35:0] col, input logic [7:0] code);
    return (col[8:0] == 9'h19C) && (col[17:9] == 9'h000) &&
           (col[26:18] == 9'h000) && (col[35:27] == {1'b0, code});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      local_fault   <= 1'b0;
      remote_fault  <= 1'b0;
      sfp_txdisable <= 1'b1;
    end else begin
      sync1         <= {sfp_prsnt_n, sfp_los, rx_ready, tx_ready, pll_locked};
      sync2         <= sync1;
      local_fault   <= col_match(xgmii_rx_dc[35:0], 8'h01) | col_match(xgmii_rx_dc[71:36], 8'h01);
      remote_fault  <= col_match(xgmii_rx_dc[35:0], 8'h02) | col_match(xgmii_rx_dc[71:36], 8'h02);
      sfp_txdisable <= prsnt_n_s;
    end
  end

  always_comb begin
    nxt           = st;
    timer_nxt     = timer;
    fault_cnt_nxt = '0;
    retry_inc     = 1'b0;
    if (prsnt_n_s) begin
      nxt       = S_RST;
      timer_nxt = '0;
    end else if (st != S_RST && !pll_s) begin
      nxt       = S_RST;
      timer_nxt = '0;
      retry_inc = (st == S_UP);
    end else begin
      case (st)
        S_RST:
          if (timer == TW'(RST_PULSE - 1)) begin
            nxt       = S_WAIT_LOCK;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        S_WAIT_LOCK:
          if (pll_s && tx_s) begin
            nxt       = S_WAIT_RX;
            timer_nxt = '0;
          end
        S_WAIT_RX:
          if (rx_s && !los_s) begin
            nxt       = S_SETTLE;
            timer_nxt = '0;
          end else if (timer == TW'(RX_TIMEOUT - 1)) begin
            nxt       = S_RST;
            timer_nxt = '0;
            retry_inc = 1'b1;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        S_SETTLE:
          if (!rx_s || los_s) begin
            nxt       = S_WAIT_RX;
            timer_nxt = '0;
          end else if (fault) begin
            timer_nxt = '0;
          end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
            nxt       = S_UP;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        S_UP:
          if (los_s || !rx_s) begin
            nxt       = S_RST;
            timer_nxt = '0;
            retry_inc = 1'b1;
          end else if (fault) begin
            if (fault_cnt == FW'(FAULT_LIMIT - 1)) begin
              nxt       = S_SETTLE;
              timer_nxt = '0;
            end else begin
              fault_cnt_nxt = fault_cnt + FW'(1);
            end
          end
        default: begin
          nxt       = S_RST;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move together with state
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_RST;
      timer       <= '0;
      fault_cnt   <= '0;
      retry_count <= 8'd0;
      phy_rst     <= 1'b1;
      mac_rst     <= 1'b1;
      link_up     <= 1'b0;
    end else begin
      st        <= nxt;
      timer     <= timer_nxt;
      fault_cnt <= fault_cnt_nxt;
      if (retry_inc && retry_count != 8'hFF)
        retry_count <= retry_count + 8'd1;
      phy_rst   <= (nxt == S_RST);
      mac_rst   <= (nxt != S_UP);
      link_up   <= (nxt == S_UP);
    end
  end

endmodule

// File: tb/tb_xgmii_link_sequencer.sv
// tb/tb_xgmii_link_sequencer.sv - directed self-checking bench for xgmii_link_sequencer
module tb_xgmii_link_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_locked, tx_ready, rx_ready, sfp_los, sfp_prsnt_n;
  logic [71:0] xgmii_rx_dc;
  logic        phy_rst, mac_rst, sfp_txdisable, link_up, local_fault, remote_fault;
  logic [2:0]  state;
  logic [7:0]  retry_count;

  int checks = 0;
  int errors = 0;
  int n;

  localparam logic [35:0] IDLE_COL = {4{9'h107}};
  localparam logic [35:0] LF_COL   = {9'h001, 9'h000, 9'h000, 9'h19C};
  localparam logic [35:0] RF_COL   = {9'h002, 9'h000, 9'h000, 9'h19C};

  xgmii_link_sequencer #(
    .RST_PULSE(64), .RX_TIMEOUT(1000), .SETTLE_CYCLES(1024), .FAULT_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .tx_ready(tx_ready),
    .rx_ready(rx_ready), .sfp_los(sfp_los), .sfp_prsnt_n(sfp_prsnt_n),
    .xgmii_rx_dc(xgmii_rx_dc), .phy_rst(phy_rst), .mac_rst(mac_rst),
    .sfp_txdisable(sfp_txdisable), .link_up(link_up), .state(state),
    .retry_count(retry_count), .local_fault(local_fault), .remote_fault(remote_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // sel: 0 = state, 1 = phy_rst, 2 = link_up; returns edges taken (bound if never seen)
  task automatic wait_on(input int sel, input logic [7:0] val, input int bound, output int cnt);
    logic [7:0] v;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      case (sel)
        0:       v = {5'b0, state};
        1:       v = {7'b0, phy_rst};
        default: v = {7'b0, link_up};
      endcase
      if (v === val || cnt >= bound) break;
    end
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b1; tx_ready = 1'b1; rx_ready = 1'b1;
    sfp_los = 1'b0; sfp_prsnt_n = 1'b0; xgmii_rx_dc = {IDLE_COL, IDLE_COL};
    step(3);
    chk("rst_phy_rst", phy_rst, 1);
    chk("rst_mac_rst", mac_rst, 1);
    chk("rst_txdisable", sfp_txdisable, 1);
    chk("rst_link_up", link_up, 0);
    chk("rst_state", state, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_lf", local_fault, 0);
    chk("rst_rf", remote_fault, 0);

    // Clean bring-up
    rst = 1'b0;
    wait_on(1, 8'd0, 200, n);
    chk("phy_rst_fall_cycles", n, 64);
    wait_on(2, 8'd1, 3000, n);
    chk("link_up_cycles", n, 1026);
    chk("up_mac_rst", mac_rst, 0);
    chk("up_state", state, 4);
    chk("up_retry", retry_count, 0);
    chk("up_txdisable", sfp_txdisable, 0);

    // 15 remote-fault cycles: tolerated
    xgmii_rx_dc = {IDLE_COL, RF_COL};
    step(1);
    chk("rf_pulse", remote_fault, 1);
    chk("rf_no_lf", local_fault, 0);
    step(14);
    xgmii_rx_dc = {IDLE_COL, IDLE_COL};
    step(5);
    chk("rf15_state", state, 4);
    chk("rf15_link_up", link_up, 1);

    // 16 remote-fault cycles: drop to SETTLE
    xgmii_rx_dc = {IDLE_COL, RF_COL};
    step(16);
    chk("rf16_still_up", state, 4);
    xgmii_rx_dc = {IDLE_COL, IDLE_COL};
    step(1);
    chk("rf16_state", state, 3);
    chk("rf16_link_up", link_up, 0);
    chk("rf16_mac_rst", mac_rst, 1);

    // Local fault in upper column at settle cycle 500 restarts the settle timer
    step(500);
    xgmii_rx_dc = {LF_COL, IDLE_COL};
    step(1);
    chk("lf_pulse", local_fault, 1);
    chk("lf_no_rf", remote_fault, 0);
    xgmii_rx_dc = {IDLE_COL, IDLE_COL};
    step(1);
    chk("lf_pulse_end", local_fault, 0);
    chk("lf_settle_state", state, 3);
    wait_on(2, 8'd1, 2000, n);
    chk("lf_relink_cycles", n, 1024);

    // Loss of signal in UP
    sfp_los = 1'b1;
    wait_on(0, 8'd0, 10, n);
    chk("los_cycles", n, 3);
    chk("los_link_up", link_up, 0);
    chk("los_phy_rst", phy_rst, 1);
    chk("los_retry", retry_count, 1);

    // Module removal holds RST without counting a retry
    sfp_prsnt_n = 1'b1; sfp_los = 1'b0; rx_ready = 1'b0;
    step(3);
    chk("removed_txdisable", sfp_txdisable, 1);
    step(200);
    chk("removed_state", state, 0);
    chk("removed_phy_rst", phy_rst, 1);
    chk("removed_retry", retry_count, 1);

    // RX never locks: timeout and retry three times
    sfp_prsnt_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_on(0, 8'd2, 300, n);
      chk("wait_rx_state", state, 2);
      wait_on(0, 8'd0, 2000, n);
      chk("rx_timeout_cycles", n, 1000);
      chk("rx_timeout_retry", retry_count, 1 + i);
      wait_on(1, 8'd0, 200, n);
      chk("retry_phy_rst_cycles", n, 64);
    end
    chk("present_txdisable", sfp_txdisable, 0);

    // PLL drop in SETTLE: back to RST, no retry increment
    rx_ready = 1'b1;
    wait_on(0, 8'd3, 20, n);
    chk("settle_reached", state, 3);
    pll_locked = 1'b0;
    wait_on(0, 8'd0, 10, n);
    chk("pll_drop_cycles", n, 3);
    chk("pll_drop_retry", retry_count, 4);

    // Reset mid-sequence
    pll_locked = 1'b1;
    step(10);
    chk("mid_phy_rst", phy_rst, 1);
    rst = 1'b1;
    step(1);
    chk("rst2_phy_rst", phy_rst, 1);
    chk("rst2_mac_rst", mac_rst, 1);
    chk("rst2_txdisable", sfp_txdisable, 1);
    chk("rst2_link_up", link_up, 0);
    chk("rst2_state", state, 0);
    chk("rst2_retry", retry_count, 0);
    chk("rst2_lf", local_fault, 0);
    chk("rst2_rf", remote_fault, 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_retry", retry_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
